deposit_money: RTL and testbench

Upstream money-intake stage of the vending machine. Debounces raw coin-slot codes and accumulates a saturating 4-bit credit balance. Publishes the balance as `pmoney` to the withdraw/display stage and services its withdraw requests with an ack/error handshake. Also performs a full refund on cancel.

---
 rtl/deposit_money_pkg.sv | 31 +++
 rtl/deposit_money_if.sv | 34 +++
 rtl/deposit_money_coin_debounce.sv | 85 ++++++++
 rtl/deposit_money.sv | 109 ++++++++++
 tb/tb_deposit_money.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/deposit_money_pkg.sv
`default_nettype none
// ==========================================================================
// vending_pkg -- coin codes, debouncer states and money width for intake.
// Revision: 1.0
// ==========================================================================
package vending_pkg;

   localparam int MONEY_W = 4;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_1    = 2'b01;
   localparam logic [1:0] COIN_2    = 2'b10;
   localparam logic [1:0] COIN_5    = 2'b11;

   typedef enum logic [1:0] {
      DB_IDLE         = 2'd0,
      DB_COUNT        = 2'd1,
      DB_WAIT_RELEASE = 2'd2
   } db_state_e;

   function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_1:  return 4'd1;
         COIN_2:  return 4'd2;
         COIN_5:  return 4'd5;
         default: return 4'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/deposit_money_if.sv
`default_nettype none
// ==========================================================================
// deposit_money_if -- coin slot, cancel, withdraw and refund signal bundle.
// Revision: 1.0
// ==========================================================================
interface deposit_money_if;
   import vending_pkg::*;

   logic [1:0]         coin_in;
   logic               cancel;
   logic               withdraw_req;
   logic [MONEY_W-1:0] withdrawmoney;
   logic [MONEY_W-1:0] pmoney;
   logic               withdraw_ack;
   logic               withdraw_err;
   logic               coin_reject;
   logic               refund_valid;
   logic [MONEY_W-1:0] refund_amount;
   logic               full;

   modport master (
      output coin_in, cancel, withdraw_req, withdrawmoney,
      input  pmoney, withdraw_ack, withdraw_err, coin_reject,
             refund_valid, refund_amount, full
   );

   modport slave (
      input  coin_in, cancel, withdraw_req, withdrawmoney,
      output pmoney, withdraw_ack, withdraw_err, coin_reject,
             refund_valid, refund_amount, full
   );

endinterface
`default_nettype wire

// File: rtl/deposit_money_coin_debounce.sv
`default_nettype none
// ==========================================================================
// coin_debounce -- accepts a coin after DEBOUNCE_CYCLES identical samples.
// Revision: 1.0
// ==========================================================================
module coin_debounce
   import vending_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  wire logic       clock,
   input  wire logic       reset_n,
   input  wire logic [1:0] coin_in,
   output logic            coin_valid,
   output logic [1:0]      coin_code
);

   localparam logic [4:0] DEB_LIMIT = 5'(DEBOUNCE_CYCLES);

   db_state_e  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] code_q, code_d;
   logic       coin_valid_q, coin_valid_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= DB_IDLE;
         cnt_q        <= 4'd0;
         code_q       <= COIN_NONE;
         coin_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         code_q       <= code_d;
         coin_valid_q <= coin_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      code_d       = code_q;
      coin_valid_d = 1'b0;
      case (state_q)
         DB_IDLE: begin
            if (coin_in != COIN_NONE) begin
               code_d  = coin_in;
               cnt_d   = 4'd1;
               state_d = DB_COUNT;
            end
         end
         DB_COUNT: begin
            if (coin_in == code_q) begin
               cnt_d = cnt_q + 4'd1;
               if (({1'b0, cnt_q} + 5'd1) == DEB_LIMIT) begin
                  coin_valid_d = 1'b1;
                  state_d      = DB_WAIT_RELEASE;
               end
            end else if (coin_in == COIN_NONE) begin
               cnt_d   = 4'd0;
               state_d = DB_IDLE;
            end else begin
               // a different nonzero code restarts the run with the new coin
               code_d = coin_in;
               cnt_d  = 4'd1;
            end
         end
         DB_WAIT_RELEASE: begin
            if (coin_in == COIN_NONE) begin
               cnt_d   = 4'd0;
               state_d = DB_IDLE;
            end
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = DB_IDLE;
         end
      endcase
   end

   assign coin_valid = coin_valid_q;
   assign coin_code  = code_q;

endmodule
`default_nettype wire

// File: rtl/deposit_money.sv
`default_nettype none
// ==========================================================================
// deposit_money -- debounced coin intake, saturating balance, withdraw/refund.
// Revision: 1.0
// ==========================================================================
module deposit_money
   import vending_pkg::*;
#(
   parameter int MAX_BALANCE     = 15,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  wire logic       clock,
   input  wire logic       reset_n,
   deposit_money_if.slave  bus
);

   localparam logic [4:0] MAX_W = 5'(MAX_BALANCE);

   logic       coin_valid;
   logic [1:0] coin_code;

   logic [MONEY_W-1:0] pmoney_q, pmoney_d;
   logic [MONEY_W-1:0] refund_amount_q, refund_amount_d;
   logic               withdraw_ack_q, withdraw_ack_d;
   logic               withdraw_err_q, withdraw_err_d;
   logic               coin_reject_q, coin_reject_d;
   logic               refund_valid_q, refund_valid_d;

   logic [4:0] bal_w, wamt_w, coin_w, draw_w, net_w;

   coin_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_coin_debounce (
      .clock      (clock),
      .reset_n    (reset_n),
      .coin_in    (bus.coin_in),
      .coin_valid (coin_valid),
      .coin_code  (coin_code)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pmoney_q        <= '0;
         refund_amount_q <= '0;
         withdraw_ack_q  <= 1'b0;
         withdraw_err_q  <= 1'b0;
         coin_reject_q   <= 1'b0;
         refund_valid_q  <= 1'b0;
      end else begin
         pmoney_q        <= pmoney_d;
         refund_amount_q <= refund_amount_d;
         withdraw_ack_q  <= withdraw_ack_d;
         withdraw_err_q  <= withdraw_err_d;
         coin_reject_q   <= coin_reject_d;
         refund_valid_q  <= refund_valid_d;
      end
   end

   // 5-bit working values so the ceiling compare can never wrap
   always_comb begin
      bal_w           = {1'b0, pmoney_q};
      wamt_w          = {1'b0, bus.withdrawmoney};
      coin_w          = {1'b0, coin_value(coin_code)};
      draw_w          = 5'd0;
      net_w           = bal_w;
      pmoney_d        = pmoney_q;
      refund_amount_d = refund_amount_q;
      withdraw_ack_d  = 1'b0;
      withdraw_err_d  = 1'b0;
      coin_reject_d   = 1'b0;
      refund_valid_d  = 1'b0;

      if (bus.cancel) begin
         refund_amount_d = pmoney_q;
         refund_valid_d  = 1'b1;
         pmoney_d        = '0;
         coin_reject_d   = coin_valid;
         withdraw_err_d  = bus.withdraw_req;
      end else begin
         if (bus.withdraw_req) begin
            if ((wamt_w != 5'd0) && (wamt_w <= bal_w)) begin
               draw_w         = wamt_w;
               withdraw_ack_d = 1'b1;
            end else begin
               withdraw_err_d = 1'b1;
            end
         end
         net_w = bal_w - draw_w;
         if (coin_valid) begin
            if ((net_w + coin_w) <= MAX_W) begin
               net_w = net_w + coin_w;
            end else begin
               coin_reject_d = 1'b1;
            end
         end
         pmoney_d = net_w[MONEY_W-1:0];
      end
   end

   assign bus.pmoney        = pmoney_q;
   assign bus.refund_amount = refund_amount_q;
   assign bus.withdraw_ack  = withdraw_ack_q;
   assign bus.withdraw_err  = withdraw_err_q;
   assign bus.coin_reject   = coin_reject_q;
   assign bus.refund_valid  = refund_valid_q;
   assign bus.full          = ({1'b0, pmoney_q} == MAX_W);

endmodule
`default_nettype wire

// File: tb/tb_deposit_money.sv
`default_nettype none
// ==========================================================================
// tb_deposit_money -- scoreboard bench with a behavioural intake model.
// Revision: 1.0
// ==========================================================================
module tb_deposit_money;
   import vending_pkg::*;

   localparam int MAXB = 15;
   localparam int DEB  = 4;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   deposit_money_if bus ();

   deposit_money #(
      .MAX_BALANCE     (MAXB),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] pm;
      logic       ack;
      logic       err;
      logic       rej;
      logic       rv;
      logic [3:0] ramt;
      logic       full;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // model state: balance, last refund, coin due for crediting at next edge,
   // and the run length of identical nonzero samples since the slot emptied
   int m_bal, m_ramt, m_pend, m_run, m_last;
   bit m_locked;

   function automatic int cval(input logic [1:0] c);
      case (c)
         2'b01:   return 1;
         2'b10:   return 2;
         2'b11:   return 5;
         default: return 0;
      endcase
   endfunction

   function automatic obs_t snap();
      obs_t s;
      s.pm   = bus.pmoney;
      s.ack  = bus.withdraw_ack;
      s.err  = bus.withdraw_err;
      s.rej  = bus.coin_reject;
      s.rv   = bus.refund_valid;
      s.ramt = bus.refund_amount;
      s.full = bus.full;
      return s;
   endfunction

   task automatic check_obs(input string name, input obs_t act, input obs_t req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s @%0t: got pm=%0d ack=%0b err=%0b rej=%0b rv=%0b ramt=%0d full=%0b, required pm=%0d ack=%0b err=%0b rej=%0b rv=%0b ramt=%0d full=%0b",
                    name, $time, act.pm, act.ack, act.err, act.rej, act.rv, act.ramt, act.full,
                    req.pm, req.ack, req.err, req.rej, req.rv, req.ramt, req.full);
   endtask

   task automatic check_val(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, req);
   endtask

   task automatic model_reset();
      m_bal = 0; m_ramt = 0; m_pend = 0; m_run = 0; m_last = 0; m_locked = 1'b0;
   endtask

   // Drive one cycle of inputs (called at a negedge), predict the outputs
   // after the coming posedge, then return at the following negedge.
   task automatic step(input logic [1:0] c, input bit can, input bit wr, input logic [3:0] wm);
      obs_t e;
      int   b;
      int   w;
      bus.coin_in       = c;
      bus.cancel        = can;
      bus.withdraw_req  = wr;
      bus.withdrawmoney = wm;
      e = '0;
      b = m_bal;
      w = 0;
      if (can) begin
         e.rv   = 1'b1;
         e.rej  = (m_pend > 0);
         e.err  = wr;
         m_ramt = b;
         m_bal  = 0;
      end else begin
         if (wr) begin
            if (int'(wm) != 0 && int'(wm) <= b) begin
               w     = int'(wm);
               e.ack = 1'b1;
            end else begin
               e.err = 1'b1;
            end
         end
         m_bal = b - w;
         if (m_pend > 0) begin
            if (m_bal + m_pend <= MAXB) m_bal = m_bal + m_pend;
            else e.rej = 1'b1;
         end
      end
      e.pm   = 4'(m_bal);
      e.ramt = 4'(m_ramt);
      e.full = (m_bal == MAXB);

      m_pend = 0;
      if (c == 2'b00) begin
         m_run    = 0;
         m_locked = 1'b0;
      end else begin
         m_run = (int'(c) == m_last) ? m_run + 1 : 1;
         if (!m_locked && m_run == DEB) begin
            m_pend   = cval(c);
            m_locked = 1'b1;
         end
      end
      m_last = int'(c);
      exp_q.push_back(e);
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) step(2'b00, 1'b0, 1'b0, 4'd0);
   endtask

   // hold a coin for exactly DEB samples; the release sample carries the
   // optional concurrent withdraw/cancel that meets the credit edge
   task automatic coin_with(input logic [1:0] c, input bit can, input bit wr, input logic [3:0] wm);
      repeat (DEB) step(c, 1'b0, 1'b0, 4'd0);
      step(2'b00, can, wr, wm);
      idle(1);
   endtask

   task automatic coin(input logic [1:0] c);
      coin_with(c, 1'b0, 1'b0, 4'd0);
   endtask

   initial begin : monitor
      obs_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_obs("cycle", snap(), e);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [1:0] cur;
      bus.coin_in       = 2'b00;
      bus.cancel        = 1'b0;
      bus.withdraw_req  = 1'b0;
      bus.withdrawmoney = 4'd0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      check_obs("reset", snap(), obs_t'('0));
      reset_n = 1'b1;

      // coin credit, then a long hold credited once
      coin(2'b10);
      check_val("credit_2", int'(bus.pmoney), 2);
      repeat (20) step(2'b10, 1'b0, 1'b0, 4'd0);
      idle(2);
      check_val("held_once", int'(bus.pmoney), 4);

      // glitch rejection
      step(2'b01, 0, 0, 0); step(2'b01, 0, 0, 0); step(2'b00, 0, 0, 0);
      coin(2'b01);
      check_val("glitch_1", int'(bus.pmoney), 5);
      step(2'b01, 0, 0, 0); step(2'b01, 0, 0, 0);
      coin(2'b11);
      check_val("switch_5", int'(bus.pmoney), 10);

      // saturation
      coin(2'b10);
      coin(2'b11);
      check_val("sat_hold", int'(bus.pmoney), 12);
      coin(2'b10);
      coin(2'b01);
      check_val("full", int'(bus.full), 1);

      // withdraw handshake
      step(2'b00, 0, 1, 4'd8);
      step(2'b00, 0, 1, 4'd3);
      check_val("wd_ack", int'(bus.pmoney), 4);
      step(2'b00, 0, 1, 4'd9);
      step(2'b00, 0, 1, 4'd0);
      check_val("wd_err", int'(bus.withdraw_err), 1);

      // simultaneous withdraw and coin
      coin(2'b11);
      coin(2'b11);
      coin_with(2'b11, 1'b0, 1'b1, 4'd4);
      check_val("sim_ack", int'(bus.pmoney), 15);
      step(2'b00, 0, 1, 4'd1);
      coin_with(2'b11, 1'b0, 1'b1, 4'd0);
      check_val("sim_rej", int'(bus.pmoney), 14);

      // cancel with concurrent coin and withdraw
      step(2'b00, 0, 1, 4'd5);
      coin_with(2'b11, 1'b1, 1'b1, 4'd3);
      check_val("refund_amt", int'(bus.refund_amount), 9);

      // asynchronous reset in the middle of a debounce run
      coin(2'b10);
      step(2'b01, 0, 0, 0);
      step(2'b01, 0, 0, 0);
      #2 reset_n = 1'b0;
      #1 check_obs("async_reset", snap(), obs_t'('0));
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      coin(2'b01);
      check_val("recount", int'(bus.pmoney), 1);

      // randomized traffic
      cur = 2'b00;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0)
            cur = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         step(cur, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
              4'($urandom_range(0, 9)));
      end
      idle(2);

      check_val("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
